// File: rtl/reg_file_mp.sv
// Multi-ported register file with a per-register busy scoreboard for reservations.
// Define REG_FILE_MP_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_mp #(
    parameter int NUM_REGS     = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_WR_PORTS = 2,
    localparam int AW          = $clog2(NUM_REGS)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_RD_PORTS*AW-1:0]         rd_addr_i,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data_o,
    output logic [NUM_RD_PORTS-1:0]            rd_busy_o,
    input  logic [NUM_WR_PORTS-1:0]            wr_en_i,
    input  logic [NUM_WR_PORTS*AW-1:0]         wr_addr_i,
    input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0] wr_data_i,
    input  logic                               resv_en_i,
    input  logic [AW-1:0]                      resv_addr_i,
    output logic [NUM_REGS-1:0]                busy_vec_o
);

    logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;

    logic [AW-1:0]         wr_addr [NUM_WR_PORTS];
    logic [DATA_WIDTH-1:0] wr_data [NUM_WR_PORTS];
    logic                  wr_live [NUM_WR_PORTS];
    logic [AW-1:0]         rd_addr [NUM_RD_PORTS];

    always_comb begin
        for (int k = 0; k < NUM_WR_PORTS; k++) begin
            wr_addr[k] = wr_addr_i[k*AW +: AW];
            wr_data[k] = wr_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            wr_live[k] = wr_en_i[k] && (wr_addr_i[k*AW +: AW] != '0);
        end
        for (int j = 0; j < NUM_RD_PORTS; j++) begin
            rd_addr[j] = rd_addr_i[j*AW +: AW];
        end
    end

    // Ports are applied in ascending order so the highest-numbered port wins a collision;
    // the reservation is applied after the write clears so it wins on the same register.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        for (int k = 0; k < NUM_WR_PORTS; k++) begin
            if (wr_live[k]) begin
                mem_d[wr_addr[k]]  = wr_data[k];
                busy_d[wr_addr[k]] = 1'b0;
            end
        end
        if (resv_en_i && (resv_addr_i != '0)) begin
            busy_d[resv_addr_i] = 1'b1;
        end
        mem_d[0]  = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int j = 0; j < NUM_RD_PORTS; j++) begin
            rd_data_o[j*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_addr[j]];
            rd_busy_o[j]                          = busy_q[rd_addr[j]];
`ifdef REG_FILE_MP_BYPASS_EN
            for (int k = 0; k < NUM_WR_PORTS; k++) begin
                if (wr_live[k] && (wr_addr[k] == rd_addr[j])) begin
                    rd_data_o[j*DATA_WIDTH +: DATA_WIDTH] = wr_data[k];
                    rd_busy_o[j] = resv_en_i && (resv_addr_i == rd_addr[j]);
                end
            end
`endif
        end
    end

    assign busy_vec_o = busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed + short random bench for reg_file_mp; a per-cycle model check backs literal checks.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr_i;
    logic [63:0] rd_data_o;
    logic [1:0]  rd_busy_o;
    logic [1:0]  wr_en_i;
    logic [9:0]  wr_addr_i;
    logic [63:0] wr_data_i;
    logic        resv_en_i;
    logic [4:0]  resv_addr_i;
    logic [31:0] busy_vec_o;

    int errs   = 0;
    int checks = 0;
    bit chk_en = 0;

    logic [31:0] m_mem [32];
    logic [31:0] m_busy;

    reg_file_mp dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o),
        .rd_busy_o  (rd_busy_o),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i),
        .resv_en_i  (resv_en_i),
        .resv_addr_i(resv_addr_i),
        .busy_vec_o (busy_vec_o)
    );

    always #5 clk = ~clk;

    // Highest enabled port targeting the address, or -1 when nothing writes it this cycle.
    function automatic int winner(input int a);
        int w;
        w = -1;
        for (int k = 0; k < 2; k++)
            if (wr_en_i[k] && int'(wr_addr_i[k*5 +: 5]) == a) w = k;
        return w;
    endfunction

    function automatic logic [31:0] exp_data(input int a);
        logic [31:0] v;
        v = (a == 0) ? 32'h0 : m_mem[a];
`ifdef REG_FILE_MP_BYPASS_EN
        if (a != 0 && winner(a) >= 0) v = wr_data_i[winner(a)*32 +: 32];
`endif
        return v;
    endfunction

    function automatic logic exp_busy(input int a);
        logic b;
        b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REG_FILE_MP_BYPASS_EN
        if (a != 0 && winner(a) >= 0) b = resv_en_i && (int'(resv_addr_i) == a);
`endif
        return b;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < 32; a++) m_mem[a] = 32'h0;
            m_busy = 32'h0;
        end else begin
            for (int a = 1; a < 32; a++) begin
                if (winner(a) >= 0) begin
                    m_mem[a]  = wr_data_i[winner(a)*32 +: 32];
                    m_busy[a] = 1'b0;
                end
                if (resv_en_i && int'(resv_addr_i) == a) m_busy[a] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int j = 0; j < 2; j++) begin
                checks++;
                if (rd_data_o[j*32 +: 32] !== exp_data(int'(rd_addr_i[j*5 +: 5]))) begin
                    errs++;
                    $display("FAIL model_rd_data port%0d addr=%0d got=%h exp=%h", j,
                             rd_addr_i[j*5 +: 5], rd_data_o[j*32 +: 32],
                             exp_data(int'(rd_addr_i[j*5 +: 5])));
                end
                checks++;
                if (rd_busy_o[j] !== exp_busy(int'(rd_addr_i[j*5 +: 5]))) begin
                    errs++;
                    $display("FAIL model_rd_busy port%0d addr=%0d got=%b exp=%b", j,
                             rd_addr_i[j*5 +: 5], rd_busy_o[j],
                             exp_busy(int'(rd_addr_i[j*5 +: 5])));
                end
            end
            checks++;
            if (busy_vec_o !== m_busy) begin
                errs++;
                $display("FAIL model_busy_vec got=%h exp=%h", busy_vec_o, m_busy);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en_i   = 2'b00;
        resv_en_i = 1'b0;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
        wr_en_i[p]          = 1'b1;
        wr_addr_i[p*5 +: 5] = a;
        wr_data_i[p*32 +: 32] = d;
    endtask

    task automatic resv(input logic [4:0] a);
        resv_en_i   = 1'b1;
        resv_addr_i = a;
    endtask

    task automatic rd(input int p, input logic [4:0] a);
        rd_addr_i[p*5 +: 5] = a;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rd_addr_i = '0; wr_addr_i = '0; wr_data_i = '0;
        resv_addr_i = '0; idle();
        tick();
        chk_en = 1;
        tick();
        rst = 1'b0;

        for (int a = 0; a < 32; a++) begin
            rd_addr_i = {5'(31 - a), 5'(a)};
            #1;
            chk("reset_rd_p0", rd_data_o[31:0], 32'h0);
            chk("reset_rd_p1", rd_data_o[63:32], 32'h0);
        end
        chk("reset_busy_vec", busy_vec_o, 32'h0);
        tick();

        wr(0, 5'd5, 32'hDEADBEEF); tick(); idle();
        rd(0, 5'd5); chk("x5_after_write", rd_data_o[31:0], 32'hDEADBEEF);

        wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22); tick(); idle();
        rd(1, 5'd7); chk("x7_port1_wins", rd_data_o[63:32], 32'h22);
        wr(0, 5'd0, 32'hFFFFFFFF); tick(); idle();
        rd(0, 5'd0); chk("x0_reads_zero", rd_data_o[31:0], 32'h0);

        resv(5'd3); tick(); idle();
        rd(0, 5'd3);
        chk("x3_rd_busy", 32'(rd_busy_o[0]), 32'h1);
        chk("x3_busy_vec", busy_vec_o, 32'h8);
        wr(1, 5'd3, 32'h5A); tick(); idle();
        rd(0, 5'd3);
        chk("x3_busy_cleared", busy_vec_o, 32'h0);
        chk("x3_data", rd_data_o[31:0], 32'h5A);

        wr(0, 5'd9, 32'h1); resv(5'd9); tick(); idle();
        rd(1, 5'd9);
        chk("x9_data", rd_data_o[63:32], 32'h1);
        chk("x9_busy_vec", busy_vec_o, 32'h200);

        wr(0, 5'd4, 32'h1111); tick(); idle();
        wr(0, 5'd4, 32'hCAFE); rd(0, 5'd4);
`ifdef REG_FILE_MP_BYPASS_EN
        chk("x4_same_cycle", rd_data_o[31:0], 32'hCAFE);
`else
        chk("x4_same_cycle", rd_data_o[31:0], 32'h1111);
`endif
        tick(); idle(); #1;
        chk("x4_next_cycle", rd_data_o[31:0], 32'hCAFE);

        resv(5'd10); tick(); idle();
        wr(1, 5'd10, 32'hAB); rd(1, 5'd10);
`ifdef REG_FILE_MP_BYPASS_EN
        chk("x10_bypass_busy", 32'(rd_busy_o[1]), 32'h0);
`else
        chk("x10_bypass_busy", 32'(rd_busy_o[1]), 32'h1);
`endif
        tick(); idle();

        resv(5'd2); wr(0, 5'd6, 32'h33); tick(); idle();
        rd(0, 5'd6);
        chk("x6_before_rst", rd_data_o[31:0], 32'h33);
        chk("busy_before_rst", busy_vec_o, 32'h204);
        rst = 1'b1; wr(1, 5'd6, 32'h77); resv(5'd5); tick();
        rst = 1'b0; idle();
        rd(0, 5'd6); rd(1, 5'd9);
        chk("x6_after_rst", rd_data_o[31:0], 32'h0);
        chk("x9_after_rst", rd_data_o[63:32], 32'h0);
        chk("busy_after_rst", busy_vec_o, 32'h0);
        tick();

        for (int i = 0; i < 60; i++) begin
            wr_en_i     = 2'($urandom);
            wr_addr_i   = 10'($urandom);
            wr_data_i   = {$urandom, $urandom};
            resv_en_i   = 1'($urandom);
            resv_addr_i = 5'($urandom);
            rd_addr_i   = (i % 3 == 0) ? {wr_addr_i[9:5], wr_addr_i[4:0]} : 10'($urandom);
            tick();
        end
        idle();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 32, giving the number of architectural registers (power of two, 2..64).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the register width in bits.
REQ-003 The block SHALL have parameter NUM_RD_PORTS, default 2, giving the number of read ports (1..4).
REQ-004 The block SHALL have parameter NUM_WR_PORTS, default 2, giving the number of write ports (1..2).
REQ-005 AW SHALL equal $clog2(NUM_REGS); port k of any flattened bus SHALL occupy slice [k*W +: W].
REQ-006 Ports SHALL be:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- rd_addr_i  in  NUM_RD_PORTS*AW  read addresses.
- rd_data_o  out  NUM_RD_PORTS*DATA_WIDTH  read data; combinational from rd_addr_i.
- rd_busy_o  out  NUM_RD_PORTS  scoreboard bit of the addressed register.
- wr_en_i  in  NUM_WR_PORTS  write enables.
- wr_addr_i  in  NUM_WR_PORTS*AW  write addresses.
- wr_data_i  in  NUM_WR_PORTS*DATA_WIDTH  write data.
- resv_en_i  in  1  reserve a destination register (mark it busy).
- resv_addr_i  in  AW  register to reserve.
- busy_vec_o  out  NUM_REGS  registered scoreboard, bit i = register i pending.

Function
REQ-007 A write with wr_en_i[k]=1 SHALL update mem[wr_addr_i[k]] at the next rising clk edge, giving a write latency of 1 cycle.
REQ-008 Register 0 SHALL always read as 0; writes and reservations to address 0 SHALL be ignored, and busy_vec_o[0] SHALL stay 0.
REQ-009 When two write ports target the same address in one cycle, port NUM_WR_PORTS-1 SHALL win, and the loser SHALL have no effect.
REQ-010 resv_en_i=1 SHALL set busy_vec_o[resv_addr_i] at the next edge.
REQ-011 A write to register r SHALL clear busy_vec_o[r] at the next edge.
REQ-012 When a reservation and a write to the same r coincide, the register SHALL take the write data and busy_vec_o[r] SHALL end as 1, because the reservation wins.
REQ-013 Reserving an already-busy register SHALL leave it busy, with no error or counting.
REQ-014 rd_busy_o[j] SHALL equal busy_vec_o[rd_addr_i[j]], subject to REQ-017.
REQ-015 Out-of-range addresses SHALL NOT occur, because NUM_REGS is a power of two.

Reset
REQ-016 On a rising clk edge with rst=1:
- all registers SHALL be 0.
- busy_vec_o SHALL be all 0.
- wr_en_i and resv_en_i in that cycle SHALL be ignored.
- rd_data_o SHALL read 0 and rd_busy_o SHALL read 0 from the following cycle onward.
- a reset asserted mid-sequence SHALL discard pending reservations.

Configuration
REQ-017 With macro REG_FILE_MP_BYPASS_EN defined, a read of register r≠0 in a cycle where a write port targets r (wr_en_i=1) SHALL:
- return that port's wr_data_i, using the REQ-009 winner.
- drive rd_busy_o low, unless resv_en_i targets r in the same cycle.
REQ-018 Without REG_FILE_MP_BYPASS_EN, rd_data_o and rd_busy_o SHALL reflect stored state only, and the new value SHALL be visible one cycle after the write.

Verification
REQ-019 Reset, then read all addresses: rd_data_o=0 and busy_vec_o=0; then write port0 x5=0xDEADBEEF and read x5 next cycle -> 0xDEADBEEF.
REQ-020 In the same cycle, port0 writes x7=0x11 and port1 writes x7=0x22 -> x7 reads 0x22; writing x0=0xFFFFFFFF -> x0 reads 0.
REQ-021 Reserve x3, then read x3 -> rd_busy_o=1 and busy_vec_o=0x00000008; write x3=0x5A next cycle -> busy clears and data is 0x5A.
REQ-022 Write x9=0x1 with a reservation of x9 in the same cycle -> x9=0x1 and busy_vec_o[9]=1.
REQ-023 Bypass build, write x4=0xCAFE while reading x4 in the same cycle -> rd_data_o=0xCAFE; non-bypass build -> old value, then 0xCAFE the next cycle.
REQ-024 Reserve x2 and write x6=0x33, then assert rst for 1 cycle -> x6=0 and busy_vec_o=0; writes during the rst cycle have no effect.
